irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter BASE, default 16'h0040, word address of register block; block decodes io_addr[15:3] == BASE[15:3].
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth per source (legal 2..3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_rd  input  1  CPU IO read strobe, single cycle.
REQ-006 io_wr  input  1  CPU IO write strobe, single cycle.
REQ-007 io_addr  input  16  IO address (CPU top of stack).
REQ-008 io_wdata  input  16  IO write data (CPU next of stack).
REQ-009 io_rdata  output  16  IO read data, combinational, 0 when not selected.
REQ-010 irq_src  input  8  asynchronous interrupt sources, bit 0 highest priority.
REQ-011 interrupt_request  output  1  registered request to CPU interrupt input.

Function
REQ-012 Select = io_addr[15:3] == BASE[15:3]; offset = io_addr[2:0]; write occurs only when io_wr & select.
REQ-013 Offset 0 PENDING: read pending[7:0]; write-1-to-clear per bit.
REQ-014 Offset 1 MASK: read/write mask[7:0]; 1 = source enabled.
REQ-015 Offset 2 MODE: read/write mode[7:0]; 1 = rising-edge, 0 = level-high.
REQ-016 Offset 3 VECTOR: read {valid, 12'b0, idx[2:0]}; idx = lowest i with pending[i]&mask[i]; valid = any such bit; idx = 0 when not valid; writes ignored.
REQ-017 Offset 4 SWSET: write-1-to-set pending bits; reads return 0.
REQ-018 Offsets 5-7 reserved: reads 0, writes ignored; upper byte of io_wdata ignored for all registers.
REQ-019 io_rdata = selected register value when io_rd & select, else 16'h0000 (bus may OR it with other peripherals).
REQ-020 Each irq_src bit passes through SYNC_STAGES flops; plus one history flop s_prev of synchronized value, updated every cycle regardless of mode.
REQ-021 Hardware set: edge mode sets pending[i] when sync[i] & ~s_prev[i]; level mode sets pending[i] every cycle sync[i] is 1.
REQ-022 Pending bits set independently of mask; masking only gates request and VECTOR.
REQ-023 Same-cycle hardware set and W1C on one bit: set wins, bit remains 1.
REQ-024 Same-cycle SWSET and hardware set: bit 1; W1C on other bits unaffected.
REQ-025 Level-mode bit cleared by W1C re-sets next cycle while synchronized source still high.
REQ-026 Changing MODE does not generate an edge; edge detection uses s_prev only.
REQ-027 interrupt_request registered: next value = |(pending & mask), computed from post-update register state of previous cycle (one cycle after pending/mask change).
REQ-028 Latency, SYNC_STAGES=2, unmasked edge source: irq_src high before edge k -> pending set after edge k+2 -> interrupt_request high after edge k+3.
REQ-029 Mask write 0 on active source: interrupt_request low one cycle after write cycle; pending unchanged.
REQ-030 interrupt_request deasserts one cycle after the W1C that empties pending&mask; the CPU's own interrupt enable handles re-entry, block does not track acknowledge.
REQ-031 Pulse on irq_src shorter than one clk period may be missed; pulses >= 2 clk periods in edge mode always captured exactly once.

Reset
REQ-032 reset asserted: synchronizers, s_prev, pending, mask, mode, interrupt_request cleared to 0 immediately, independent of clk.
REQ-033 Reset mid-operation discards pending events; after release a source already high is seen as a rising edge in edge mode (s_prev = 0).
REQ-034 io_rdata combinational; 0 during reset unless read selected (registers read 0).

Verification
REQ-035 Reset, write MASK=0x04, MODE=0x04; raise irq_src[2] -> PENDING=0x04 after 3 clks, interrupt_request=1 after 4 clks, VECTOR=0x8002.
REQ-036 Edge sources 1 and 5 pending, mask 0xFF -> VECTOR=0x8001; W1C 0x02 -> VECTOR=0x8005; W1C 0x20 -> VECTOR=0x0000, interrupt_request low next clk.
REQ-037 Level mode bit 3 held high, W1C 0x08 -> PENDING reads 0x08 again one clk later; drop source then W1C -> stays 0.
REQ-038 Edge event on bit 0 in same cycle as W1C 0x01 -> PENDING bit 0 remains 1.
REQ-039 SWSET 0x80 with mask 0x00 -> PENDING=0x80, interrupt_request=0; write MASK=0x80 -> request 1 clk later; read of offset 6 or unselected address -> 0x0000.
REQ-040 Assert reset between edge and pending set on bit 4 -> all registers 0, request 0; release with irq_src[4] high, mode bit 4 edge after re-configuration -> no event until source re-rises (s_prev tracked during config).

Source files
------------

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Eight-source interrupt controller on the CPU IO bus. Holds
//               per-source pending/mask/mode state, synchronizes the sources,
//               and drives a registered interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter logic [15:0] BASE        = 16'h0040,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic [7:0]  irq_src,
    output logic        interrupt_request
);

    localparam logic [2:0] c_OFF_PENDING = 3'd0;
    localparam logic [2:0] c_OFF_MASK    = 3'd1;
    localparam logic [2:0] c_OFF_MODE    = 3'd2;
    localparam logic [2:0] c_OFF_VECTOR  = 3'd3;
    localparam logic [2:0] c_OFF_SWSET   = 3'd4;

    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0]  r_prev;
    logic [7:0]  r_pending;
    logic [7:0]  r_mask;
    logic [7:0]  r_mode;
    logic        r_irq;

    logic        w_sel;
    logic [2:0]  w_off;
    logic        w_wr;
    logic [7:0]  w_wbyte;
    logic [7:0]  w_sync;
    logic [7:0]  w_hw_set;
    logic [7:0]  w_w1c;
    logic [7:0]  w_swset;
    logic [7:0]  w_pending_nxt;
    logic [7:0]  w_active;
    logic        w_vec_valid;
    logic [2:0]  w_vec_idx;
    logic [15:0] w_reg_val;
    logic        w_unused_wdata;

    assign w_sel          = (io_addr[15:3] == BASE[15:3]);
    assign w_off          = io_addr[2:0];
    assign w_wr           = io_wr & w_sel;
    assign w_wbyte        = io_wdata[7:0];
    assign w_unused_wdata = ^io_wdata[15:8];

    // Oldest stage of the chain feeds edge detection and level sensing.
    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_hw_set = (r_mode & w_sync & ~r_prev) | (~r_mode & w_sync);

    assign w_w1c   = (w_wr && w_off == c_OFF_PENDING) ? w_wbyte : 8'h00;
    assign w_swset = (w_wr && w_off == c_OFF_SWSET)   ? w_wbyte : 8'h00;

    // Sets are ORed in after the clear so a coincident set always wins.
    assign w_pending_nxt = (r_pending & ~w_w1c) | w_hw_set | w_swset;

    assign w_active = r_pending & r_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 8'h00;
        end else begin
            r_sync[0] <= irq_src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= w_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 8'h00;
            r_mask    <= 8'h00;
            r_mode    <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr && w_off == c_OFF_MASK) begin
                r_mask <= w_wbyte;
            end
            if (w_wr && w_off == c_OFF_MODE) begin
                r_mode <= w_wbyte;
            end
            r_irq <= |w_active;
        end
    end

    // Lowest-numbered active source has priority.
    always_comb begin
        w_vec_idx   = 3'd0;
        w_vec_valid = |w_active;
        for (int i = 7; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec_idx = i[2:0];
            end
        end
    end

    always_comb begin
        w_reg_val = 16'h0000;
        case (w_off)
            c_OFF_PENDING: w_reg_val = {8'h00, r_pending};
            c_OFF_MASK:    w_reg_val = {8'h00, r_mask};
            c_OFF_MODE:    w_reg_val = {8'h00, r_mode};
            c_OFF_VECTOR:  w_reg_val = {w_vec_valid, 12'h000, w_vec_idx};
            default:       w_reg_val = 16'h0000;
        endcase
    end

    assign io_rdata          = (io_rd && w_sel) ? w_reg_val : 16'h0000;
    assign interrupt_request = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    localparam logic [15:0] c_BASE = 16'h0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic [7:0]  irq_src;
    logic        interrupt_request;

    int n_checks = 0;
    int n_fail   = 0;

    irq_ctrl #(.BASE(c_BASE), .SYNC_STAGES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .io_rd             (io_rd),
        .io_wr             (io_wr),
        .io_addr           (io_addr),
        .io_wdata          (io_wdata),
        .io_rdata          (io_rdata),
        .irq_src           (irq_src),
        .interrupt_request (interrupt_request)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reads have no side effects, so they complete without a clock edge.
    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        io_rd   = 1'b1;
        io_addr = addr;
        #1;
        check(tag, io_rdata, exp);
        io_rd   = 1'b0;
        io_addr = 16'h0000;
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] data);
        io_wr    = 1'b1;
        io_addr  = c_BASE + {13'h0, off};
        io_wdata = data;
        tick(1);
        io_wr    = 1'b0;
        io_wdata = 16'h0000;
        io_addr  = 16'h0000;
    endtask

    initial begin
        reset    = 1'b1;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        io_addr  = 16'h0000;
        io_wdata = 16'h0000;
        irq_src  = 8'h00;
        tick(2);
        check("rst_irq", {15'h0, interrupt_request}, 16'h0000);
        rd_chk("rst_pending", c_BASE + 16'd0, 16'h0000);
        reset = 1'b0;
        tick(1);
        rd_chk("rst_vector", c_BASE + 16'd3, 16'h0000);

        // Edge source 2: latency through two sync stages.
        wr(3'd1, 16'hAB04);
        wr(3'd2, 16'h0004);
        rd_chk("mask_rd", c_BASE + 16'd1, 16'h0004);
        irq_src[2] = 1'b1;
        tick(2);
        rd_chk("lat_pend_2clk", c_BASE + 16'd0, 16'h0000);
        tick(1);
        rd_chk("lat_pend_3clk", c_BASE + 16'd0, 16'h0004);
        check("lat_irq_3clk", {15'h0, interrupt_request}, 16'h0000);
        tick(1);
        check("lat_irq_4clk", {15'h0, interrupt_request}, 16'h0001);
        rd_chk("lat_vector", c_BASE + 16'd3, 16'h8002);

        // Priority between edge sources 1 and 5.
        wr(3'd0, 16'h00FF);
        wr(3'd1, 16'h00FF);
        wr(3'd2, 16'h00FF);
        irq_src = 8'h26;
        tick(4);
        rd_chk("prio_pend", c_BASE + 16'd0, 16'h0022);
        rd_chk("prio_vec1", c_BASE + 16'd3, 16'h8001);
        wr(3'd0, 16'h0002);
        rd_chk("prio_vec5", c_BASE + 16'd3, 16'h8005);
        wr(3'd0, 16'h0020);
        rd_chk("prio_vec0", c_BASE + 16'd3, 16'h0000);
        check("prio_irq_hold", {15'h0, interrupt_request}, 16'h0001);
        tick(1);
        check("prio_irq_drop", {15'h0, interrupt_request}, 16'h0000);
        irq_src = 8'h00;
        tick(3);

        // Level mode on bit 3: clear is overridden while the source is high.
        wr(3'd2, 16'h00F7);
        irq_src[3] = 1'b1;
        tick(4);
        rd_chk("lvl_pend", c_BASE + 16'd0, 16'h0008);
        wr(3'd0, 16'h0008);
        tick(1);
        rd_chk("lvl_reset", c_BASE + 16'd0, 16'h0008);
        irq_src[3] = 1'b0;
        tick(3);
        wr(3'd0, 16'h0008);
        rd_chk("lvl_clear", c_BASE + 16'd0, 16'h0000);
        tick(1);
        rd_chk("lvl_stay0", c_BASE + 16'd0, 16'h0000);

        // Hardware edge on bit 0 lands on the same edge as its W1C.
        wr(3'd4, 16'h0001);
        rd_chk("coll_pre", c_BASE + 16'd0, 16'h0001);
        irq_src[0] = 1'b1;
        tick(2);
        wr(3'd0, 16'h0001);
        rd_chk("coll_setwins", c_BASE + 16'd0, 16'h0001);
        tick(1);
        wr(3'd0, 16'h0001);
        rd_chk("coll_once", c_BASE + 16'd0, 16'h0000);
        irq_src[0] = 1'b0;
        tick(3);

        // Software set with mask off, then unmask.
        wr(3'd1, 16'h0000);
        wr(3'd0, 16'h00FF);
        wr(3'd4, 16'hFF80);
        tick(2);
        rd_chk("sw_pend", c_BASE + 16'd0, 16'h0080);
        check("sw_irq_masked", {15'h0, interrupt_request}, 16'h0000);
        rd_chk("sw_vec_masked", c_BASE + 16'd3, 16'h0000);
        wr(3'd1, 16'h0080);
        check("sw_irq_wrcyc", {15'h0, interrupt_request}, 16'h0000);
        tick(1);
        check("sw_irq_on", {15'h0, interrupt_request}, 16'h0001);
        rd_chk("sw_vec", c_BASE + 16'd3, 16'h8007);
        wr(3'd3, 16'h0000);
        rd_chk("vec_ro", c_BASE + 16'd3, 16'h8007);
        rd_chk("rsvd6", c_BASE + 16'd6, 16'h0000);
        rd_chk("swset_rd0", c_BASE + 16'd4, 16'h0000);
        rd_chk("unsel", 16'h0048, 16'h0000);
        io_addr = c_BASE;
        #1;
        check("no_rd_strobe", io_rdata, 16'h0000);
        io_addr = 16'h0000;
        wr(3'd0, 16'h0080);

        // Reset between edge arrival and pending set on bit 4.
        wr(3'd2, 16'h0010);
        wr(3'd1, 16'h0010);
        irq_src[4] = 1'b1;
        tick(1);
        reset = 1'b1;
        #1;
        check("mid_rst_irq", {15'h0, interrupt_request}, 16'h0000);
        rd_chk("mid_rst_pend", c_BASE + 16'd0, 16'h0000);
        rd_chk("mid_rst_mask", c_BASE + 16'd1, 16'h0000);
        rd_chk("mid_rst_mode", c_BASE + 16'd2, 16'h0000);
        tick(2);
        reset = 1'b0;
        tick(4);
        wr(3'd2, 16'h0010);
        wr(3'd1, 16'h0010);
        wr(3'd0, 16'h0010);
        rd_chk("post_rst_clr", c_BASE + 16'd0, 16'h0000);
        tick(3);
        rd_chk("post_rst_noedge", c_BASE + 16'd0, 16'h0000);
        check("post_rst_irq0", {15'h0, interrupt_request}, 16'h0000);
        irq_src[4] = 1'b0;
        tick(3);
        irq_src[4] = 1'b1;
        tick(3);
        rd_chk("rerise_pend", c_BASE + 16'd0, 16'h0010);
        tick(1);
        check("rerise_irq", {15'h0, interrupt_request}, 16'h0001);
        rd_chk("rerise_vec", c_BASE + 16'd3, 16'h8004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
